// File: rtl/spi_jstk_pkg.sv
// Shared types and helpers for the SPI joystick responder: frame constants,
// FSM state encoding and the report builder.
package spi_jstk_pkg;

    localparam int          FRAME_BITS_DEF = 40;
    localparam int          REPORT_BITS    = 40;
    localparam logic [5:0]  CMD_PREFIX     = 6'b100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Byte 0 (first on the wire) sits in the top byte of the report.
    function automatic logic [REPORT_BITS-1:0] build_report(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; a pin edge shows
// up as a one-cycle pulse STAGES+1 clocks later. No backpressure.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Reset to the line's idle level so releasing reset never fakes an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_jstk_responder.sv
// Oversampled SPI mode-0 slave emulating the joystick: 40-bit command in, 40-bit
// position/button report out; SPI_JSTK_FRAME_CHECK_EN adds length checking and frame_err.
module spi_jstk_responder #(
    parameter int FRAME_BITS  = spi_jstk_pkg::FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       cmd_valid,
    output logic       frame_err
);
    import spi_jstk_pkg::*;

    logic                   cs_rise, cs_fall, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk_i(clk50M), .rst_ni(rst_n), .d_i(cs), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk_i(clk50M), .rst_ni(rst_n), .d_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_t                 state_q, state_d;
    logic [REPORT_BITS-1:0] tx_q, tx_d, rx_q, rx_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   miso_q, miso_d;
    logic [1:0]             led_q, led_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   pend_q, pend_d;
    logic                   cmd_ok;
`ifdef SPI_JSTK_FRAME_CHECK_EN
    logic                   frame_err_q, frame_err_d;

    assign cmd_ok = (rx_q[39:34] == CMD_PREFIX) && (cnt_q == 6'(FRAME_BITS));
`else
    assign cmd_ok = (rx_q[39:34] == CMD_PREFIX);
`endif

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        led_d       = led_q;
        cmd_valid_d = 1'b0;
        pend_d      = 1'b0;
`ifdef SPI_JSTK_FRAME_CHECK_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall || pend_q) begin
                    tx_d    = build_report(x_pos, y_pos, buttons);
                    miso_d  = tx_d[REPORT_BITS-1];
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Frame is judged on the way into DONE so the pulse occupies the DONE cycle.
                if (cs_rise) begin
                    state_d = ST_DONE;
                    if (cmd_ok) begin
                        led_d       = rx_q[33:32];
                        cmd_valid_d = 1'b1;
                    end else begin
`ifdef SPI_JSTK_FRAME_CHECK_EN
                        frame_err_d = 1'b1;
`endif
                    end
                end else begin
                    if (sck_rise) begin
                        rx_d  = {rx_q[REPORT_BITS-2:0], mosi_s};
                        cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
                    end
                    if (sck_fall) begin
                        tx_d   = {tx_q[REPORT_BITS-2:0], 1'b0};
                        miso_d = (cnt_q >= 6'(FRAME_BITS)) ? 1'b0 : tx_d[REPORT_BITS-1];
                    end
                end
            end
            ST_DONE: begin
                miso_d  = 1'b0;
                pend_d  = cs_fall;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            led_q       <= 2'b00;
            cmd_valid_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            led_q       <= led_d;
            cmd_valid_q <= cmd_valid_d;
            pend_q      <= pend_d;
        end
    end

`ifdef SPI_JSTK_FRAME_CHECK_EN
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else        frame_err_q <= frame_err_d;
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign miso      = miso_q;
    assign led       = led_q;
    assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_spi_jstk_responder.sv
// Bench for spi_jstk_responder: bit-banged SPI master against a byte-level
// reference model of the report and command rules.
module tb_spi_jstk_responder;
    import spi_jstk_pkg::*;

    logic       clk50M = 1'b0;
    logic       rst_n, cs, sck, mosi;
    logic       miso;
    logic [9:0] x_pos, y_pos;
    logic [2:0] buttons;
    logic [1:0] led;
    logic       cmd_valid, frame_err;

    always #10 clk50M = ~clk50M;

    spi_jstk_responder dut (
        .clk50M(clk50M), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
        .led(led), .cmd_valid(cmd_valid), .frame_err(frame_err)
    );

`ifdef SPI_JSTK_FRAME_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    int         n_tests = 0, n_fail = 0;
    int         cv_cnt = 0, fe_cnt = 0, exp_cv = 0, exp_fe = 0;
    int         last_lat;
    logic [1:0] led_m = 2'b00;

    // Every high sample counts, so a stretched pulse shows up as an extra event.
    always @(negedge clk50M) begin
        if (rst_n && cmd_valid) cv_cnt++;
        if (rst_n && frame_err) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model_report(input logic [9:0] x, input logic [9:0] y,
                                                 input logic [2:0] b);
        int     bytes[5];
        longint r;
        bytes[0] = int'(x) % 256;
        bytes[1] = int'(x) / 256;
        bytes[2] = int'(y) % 256;
        bytes[3] = int'(y) / 256;
        bytes[4] = int'(b);
        r = 0;
        for (int i = 0; i < 5; i++) r = r * 256 + longint'(bytes[i]);
        return 40'(r);
    endfunction

    // cmd is left-aligned: wire bit k is cmd[47-k]. Negative chg_bit/rst_bit disable those events.
    task automatic run_frame(input logic [47:0] cmd, input int nbits, input int half, input int gap,
                             input int chg_bit, input logic [9:0] chg_x, input int rst_bit);
        logic [39:0] rep, rxm;
        logic [47:0] got, expv, mask;
        bit          ok;
        rep = model_report(x_pos, y_pos, buttons);
        got = '0;
        rxm = '0;
        cs  = 1'b0;
        repeat (half) @(negedge clk50M);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_bit) begin
                rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; led_m = 2'b00;
                repeat (3) @(negedge clk50M);
                chk("rst_miso", 64'(miso), 64'(0));
                chk("rst_led", 64'(led), 64'(led_m));
                chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
                rst_n = 1'b1;
                repeat (4) @(negedge clk50M);
                return;
            end
            if (k == chg_bit) x_pos = chg_x;
            got[47-k] = miso;
            mosi = cmd[47-k];
            rxm  = {rxm[38:0], cmd[47-k]};
            sck  = 1'b1;
            repeat (half) @(negedge clk50M);
            sck  = 1'b0;
            repeat (half) @(negedge clk50M);
        end
        cs = 1'b1; mosi = 1'b0; last_lat = 0;
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk50M);
            if ((cmd_valid || frame_err) && last_lat == 0) last_lat = i;
        end
        expv = {rep, 8'h00};
        mask = {48{1'b1}} << (48 - nbits);
        chk("miso_bits", 64'(got & mask), 64'(expv & mask));
        ok = (rxm[39:34] == 6'b100000) && (!LEN_CHK || nbits == 40);
        if (ok) begin
            led_m = rxm[33:32];
            exp_cv++;
        end else if (LEN_CHK) begin
            exp_fe++;
        end
        if (gap >= 6) begin
            chk("led", 64'(led), 64'(led_m));
            chk("cmd_valid_cnt", 64'(cv_cnt), 64'(exp_cv));
            chk("frame_err_cnt", 64'(fe_cnt), 64'(exp_fe));
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] first;
        int         nb;
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        x_pos = '0; y_pos = '0; buttons = '0;
        repeat (3) @(negedge clk50M);
        chk("reset_miso", 64'(miso), 64'(0));
        chk("reset_led", 64'(led), 64'(0));
        chk("reset_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("reset_frame_err", 64'(frame_err), 64'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk50M);

        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        run_frame({40'h83_00_00_00_00, 8'h00}, 40, 6, 8, -1, 10'h0, -1);
        chk("pulse_lat", 64'(last_lat), 64'(4));
        chk("led_83", 64'(led), 64'(2'b11));
        run_frame({40'h81_00_00_00_00, 8'h00}, 40, 6, 8, -1, 10'h0, -1);
        chk("led_81", 64'(led), 64'(2'b01));
        run_frame({40'h00_00_00_00_00, 8'h00}, 40, 6, 8, -1, 10'h0, -1);

        run_frame({40'h82_00_00_00_00, 8'h00}, 24, 6, 8, -1, 10'h0, -1);
        run_frame({40'h83_00_00_00_00, 8'h00}, 40, 6, 8, -1, 10'h0, -1);

        x_pos = 10'h3FF;
        run_frame({40'h80_00_00_00_00, 8'h00}, 40, 6, 8, 4, 10'h000, -1);

        run_frame({40'h83_00_00_00_00, 8'h00}, 40, 6, 8, -1, 10'h0, 17);
        x_pos = 10'h2A5;
        run_frame({40'h83_00_00_00_00, 8'h00}, 40, 6, 8, -1, 10'h0, -1);

        for (int f = 0; f < 6; f++) begin
            x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 3'($urandom);
            first = {6'b100000, 2'($urandom)};
            run_frame({first, 32'($urandom), 8'($urandom)}, 40, 5, (f == 5) ? 10 : 3, -1, 10'h0, -1);
        end

        for (int f = 0; f < 20; f++) begin
            x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 3'($urandom);
            first = ($urandom_range(0, 4) < 3) ? {6'b100000, 2'($urandom)} : 8'($urandom);
            nb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 48)) : 40;
            run_frame({first, 32'($urandom), 8'($urandom)}, nb, int'($urandom_range(5, 7)), 8,
                      -1, 10'h0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
